ds_tx_char: RTL and testbench
=============================

# ds_tx_char

Serialises bytes from the transmit FIFO into IEEE 1355 DS-SE characters on a data/strobe pair, sitting at the read end of the TX FIFO, the opposite end to the writer. It pulls one byte per data character using the FIFO's fall-through read port (`r_en`/`r_data`/`fill_level`). It inserts NULLs (ESC+FCT) whenever the FIFO is empty, computes odd parity, and drives strobe so that D xor S toggles once per bit.

## Interface
- `G_ADDR_WIDTH_BITS`, 6: FIFO address width. `fifo_fill_level` is `G_ADDR_WIDTH_BITS+1` bits wide.
- `G_BIT_DIV`, 4: bit period in `clk` cycles, ≥2.
- `clk`, in, 1: single clock domain.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `tx_en`, in, 1: link transmit enable.
- `fifo_r_en`, out, 1: one-cycle FIFO read strobe.
- `fifo_r_data`, in, 8: FIFO head byte, valid whenever `fifo_fill_level` ≠ 0.
- `fifo_fill_level`, in, `G_ADDR_WIDTH_BITS+1`: FIFO occupancy.
- `credit_fct`, in, 1: flow-control credit pulse. Used only with `DS_TX_CREDIT_EN`.
- `d_out`, out, 1: DS data line.
- `s_out`, out, 1: DS strobe line.
- `char_sent`, out, 1: one-cycle pulse on the last bit of each data character.

## Operation
- **FSM states**
  - IDLE → LOAD when `tx_en`=1.
  - LOAD (one clk) → SHIFT.
  - SHIFT → LOAD at the end of the final bit if `tx_en`=1, else → IDLE.
- **Character selection in LOAD**
  - If `fifo_fill_level`≠0 (and credit>0 with the macro): data character. Capture `fifo_r_data` and pulse `fifo_r_en`.
  - Otherwise: NULL.
- **Character formats** (transmission order: P, flag, payload LSB first)
  - Data: P, 0, d0..d7. 10 bits.
  - ESC: P, 1, 1, 1.
  - FCT: P, 1, 0, 0.
  - NULL = ESC immediately followed by FCT, 8 bits. It is atomic: no data character is inserted between the ESC and the FCT.
- **Parity**
  - P = NOT(XOR of the previous character's payload bits XOR flag), giving odd parity over the previous payload plus P and flag.
  - Parity history clears on reset and on IDLE entry, so the first character after either has prev-XOR = 0.
- **Strobe**
  - Each new bit b: `d_out` ← b.
  - `s_out` toggles if b equals the previous `d_out`, otherwise holds.
- **`tx_en` deasserted mid-character**
  - The current character, including both halves of a NULL, completes.
  - Then IDLE is entered, with `d_out`=`s_out`=0 and no further `fifo_r_en`.
- **Reset**
  - All outputs are 0.
  - FSM is in IDLE, bit counter and divider are 0, parity history is cleared, credit is 0.
  - Reset asserted mid-character aborts the character at the next edge. No `fifo_r_en` is issued in that cycle.

## Timing
- **Start-up:** `tx_en` sampled high at edge N in IDLE → LOAD at N+1 → first bit on `d_out`/`s_out` at edge N+2.
- **Bit period:** each bit is held exactly `G_BIT_DIV` cycles.
- **Character length:** a data character lasts 10·`G_BIT_DIV` cycles; a NULL lasts 8·`G_BIT_DIV`.
- **Back-to-back:** the LOAD cycle overlaps the last bit cycle, so characters follow each other with no gap and no idle bit.
- **FIFO read**
  - `fifo_r_data` is captured at the LOAD edge.
  - `fifo_r_en` is high for exactly the one cycle following that edge. The FIFO advances its read pointer at the next edge.
  - At most one `fifo_r_en` per character.
- **Data-present condition:** `fifo_fill_level` is sampled only in LOAD. A byte arriving mid-NULL is sent after that NULL completes.
- **`char_sent`:** high during the first cycle of bit 9 of a data character.

## Configuration
- **`DS_TX_CREDIT_EN` defined:**
  - A 6-bit credit counter is built, range 0..56.
  - `credit_fct`=1 adds 8, saturating at 56.
  - Each data-character LOAD subtracts 1.
  - A simultaneous `credit_fct` and load gives a net +7.
  - With credit = 0, NULLs are sent even if the FIFO is non-empty.
- **Not defined:**
  - No counter is built and `credit_fct` is ignored.
  - Data is sent whenever `fifo_fill_level`≠0.

## Test plan
- **Idle NULLs:** reset, `tx_en`=1, FIFO empty, `G_BIT_DIV`=4 → repeating `d_out` bits 0,1,1,1,0,1,0,0 with `s_out` 1,1,0,1,1,1,1,0. D^S alternates every 4 clks. No `fifo_r_en`.
- **Single byte:** 0xA5 written mid-NULL → after that NULL, data bits 1,0,1,0,1,0,0,1,0,1. Exactly one `fifo_r_en`, `fill_level` 1→0, one `char_sent`. The following ESC has P=0.
- **Back-to-back:** bytes 0x01, 0x02, 0x03 preloaded → three contiguous data characters over 120 clks, `fifo_r_en` pulses spaced 40 clks apart, then NULLs.
- **`tx_en` dropped mid-character:** `tx_en`→0 at bit 3 of a data character → the character completes, then `d_out`=`s_out`=0. No further `fifo_r_en` while the FIFO still holds 2 bytes.
- **Reset mid-character:** `rst_n`=0 at bit 5 → outputs are 0 at the next edge and `fifo_fill_level` is unchanged. After release with `tx_en`=1, the stream restarts with ESC P=0.
- **Credit limit (`DS_TX_CREDIT_EN`):** FIFO holds 10 bytes, credit 0 → NULLs only. One `credit_fct` pulse → exactly 8 data characters, then NULLs with `fill_level`=2.

Source files
------------

// File: rtl/ds_tx_char_if.sv
// FIFO read port and DS line bundle for the DS-SE character transmitter.
// Latency: none, plain wires between the transmitter, its FIFO and the link pins.
// Backpressure: none; the transmitter pulls bytes and the DS lines are free-running.
interface ds_tx_char_if #(
    parameter int G_ADDR_WIDTH_BITS = 6
);
    logic                       fifo_r_en;
    logic [7:0]                 fifo_r_data;
    logic [G_ADDR_WIDTH_BITS:0] fifo_fill_level;
    logic                       d_out;
    logic                       s_out;
    logic                       char_sent;

    // Transmitter side: reads the FIFO head, drives the link
    modport master (
        output fifo_r_en, d_out, s_out, char_sent,
        input  fifo_r_data, fifo_fill_level
    );

    // FIFO / link side
    modport slave (
        input  fifo_r_en, d_out, s_out, char_sent,
        output fifo_r_data, fifo_fill_level
    );
endinterface

// File: rtl/ds_tx_char.sv
// DS-SE transmitter: serialises FIFO bytes into data chars, NULLs when empty, odd parity, DS strobe.
// Latency: first bit 2 cycles after tx_en; each bit G_BIT_DIV cycles; data char 10, NULL 8 bits.
// Backpressure: pulls one byte per data char; optional macro DS_TX_CREDIT_EN gates data on credits.
module ds_tx_char #(
    parameter int G_ADDR_WIDTH_BITS = 6,
    parameter int G_BIT_DIV         = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tx_en,
    input  logic         credit_fct,
    ds_tx_char_if.master ds
);
    localparam int               FILL_W   = G_ADDR_WIDTH_BITS + 1;
    localparam int               DIV_W    = $clog2(G_BIT_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(G_BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    // ESC flag+payload then FCT parity/flag/payload, bit 1 first; FCT parity is
    // always 0 because the ESC payload (1,1) XORs to 0.
    localparam logic [6:0]       NULL_TAIL = 7'b0010111;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q;      // cycles still to hold the bit on the line
    logic [3:0]       bit_q;      // bits of the current char already driven
    logic [9:0]       char_q;     // bits not yet driven, next one in [0]
    logic             is_data_q;
    logic             prev_xor_q; // XOR of the previous char's payload
    logic             d_q, s_q, r_en_q, sent_q;

    logic [FILL_W-1:0] fill;
    logic              have_credit;
    logic              send_data;
    logic              drive;
    logic              char_done;
    logic              last_on;
    logic              end_soon;
    logic [3:0]        char_len;
    logic [DIV_W-1:0]  rem_after;

    assign fill      = ds.fifo_fill_level;
    assign char_len  = is_data_q ? 4'd10 : 4'd8;
    assign send_data = (state_q == ST_LOAD) && (fill != '0) && have_credit;
    assign drive     = (state_q == ST_SHIFT) && (div_q == '0) && (bit_q != char_len);
    assign char_done = (state_q == ST_SHIFT) && (div_q == '0) && (bit_q == char_len);
    assign rem_after = drive ? DIV_LAST : ((div_q != '0) ? (div_q - DIV_ONE) : '0);
    assign last_on   = drive ? (bit_q == (char_len - 4'd1)) : (bit_q == char_len);
    // Two cycles before the next char's first bit: go to LOAD so the load edge
    // overlaps the tail of the last bit and characters run back to back.
    assign end_soon  = (state_q == ST_SHIFT) && last_on && (rem_after == DIV_ONE);

`ifdef DS_TX_CREDIT_EN
    logic [5:0] credit_q;
    logic [6:0] credit_sum;

    assign have_credit = (credit_q != 6'd0);
    assign credit_sum  = {1'b0, credit_q} + (credit_fct ? 7'd8 : 7'd0) - (send_data ? 7'd1 : 7'd0);

    // Credit counter: +8 per FCT, -1 per data char, saturating at 56
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_q <= 6'd0;
        end else begin
            credit_q <= (credit_sum > 7'd56) ? 6'd56 : credit_sum[5:0];
        end
    end
`else
    logic unused_credit_fct;

    assign have_credit       = 1'b1;
    assign unused_credit_fct = credit_fct;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a started character always completes before IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (tx_en) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (end_soon && tx_en) begin
                    state_d = ST_LOAD;
                end else if (char_done) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Character build, bit shifting, strobe generation and FIFO read pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q      <= '0;
            bit_q      <= 4'd0;
            char_q     <= 10'd0;
            is_data_q  <= 1'b0;
            prev_xor_q <= 1'b0;
            d_q        <= 1'b0;
            s_q        <= 1'b0;
            r_en_q     <= 1'b0;
            sent_q     <= 1'b0;
        end else begin
            r_en_q <= 1'b0;
            sent_q <= 1'b0;
            if (state_q == ST_LOAD) begin
                div_q  <= '0;
                bit_q  <= 4'd0;
                r_en_q <= send_data;
                if (send_data) begin
                    char_q     <= {ds.fifo_r_data, 1'b0, ~prev_xor_q};
                    is_data_q  <= 1'b1;
                    prev_xor_q <= ^ds.fifo_r_data;
                end else begin
                    // ESC parity = NOT(prev ^ flag 1) = prev
                    char_q     <= {2'b00, NULL_TAIL, prev_xor_q};
                    is_data_q  <= 1'b0;
                    prev_xor_q <= 1'b0;
                end
            end else if (drive) begin
                d_q    <= char_q[0];
                s_q    <= s_q ^ (char_q[0] == d_q);
                char_q <= {1'b0, char_q[9:1]};
                bit_q  <= bit_q + 4'd1;
                div_q  <= DIV_LAST;
                sent_q <= is_data_q && (bit_q == 4'd9);
            end else if (div_q != '0) begin
                div_q <= div_q - DIV_ONE;
            end
            if (state_d == ST_IDLE) begin
                d_q        <= 1'b0;
                s_q        <= 1'b0;
                prev_xor_q <= 1'b0;
                bit_q      <= 4'd0;
                div_q      <= '0;
            end
        end
    end

    assign ds.fifo_r_en = r_en_q;
    assign ds.d_out     = d_q;
    assign ds.s_out     = s_q;
    assign ds.char_sent = sent_q;
endmodule

// File: tb/tb_ds_tx_char.sv
// Randomised bench for ds_tx_char against a character-level reference model.
// Latency: model schedules chars on edge numbers (load edge, start edge, bit period).
// Backpressure: the bench FIFO pops one byte per observed fifo_r_en.
module tb_ds_tx_char;
    localparam int AW     = 6;
    localparam int DIV    = 4;
    localparam int FILL_W = AW + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic tx_en;
    logic credit_fct;

    ds_tx_char_if #(.G_ADDR_WIDTH_BITS(AW)) bus ();

    ds_tx_char #(.G_ADDR_WIDTH_BITS(AW), .G_BIT_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .credit_fct (credit_fct),
        .ds         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- FIFO model ----------------
    byte unsigned fifo_q[$];

    task automatic fifo_drive();
        bus.fifo_fill_level = FILL_W'(fifo_q.size());
        bus.fifo_r_data     = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input byte unsigned v);
        if (fifo_q.size() < 60) fifo_q.push_back(v);
        fifo_drive();
    endtask

    // ---------------- reference model ----------------
    bit m_idle = 1'b1;
    int m_load_at = -1;
    int m_stop_at = -1;
    int m_start = -1;
    int m_end = -1;
    bit m_bits[$];
    bit m_is_data = 1'b0;
    bit m_prev = 1'b0;
    bit m_d = 1'b0, m_s = 1'b0, m_ren = 1'b0, m_sent = 1'b0;
    int m_credit = 0;
    int m_fct_seen = 0;
    int ren_seen = 0;
    int ren_expected = 0;

    // Append one character: odd parity over previous payload + P + flag
    task automatic put_char(input bit flag, input logic [7:0] pl, input int n);
        bit x;
        x = 1'b0;
        for (int i = 0; i < n; i++) x ^= pl[i];
        m_bits.push_back(~(m_prev ^ flag));
        m_bits.push_back(flag);
        for (int i = 0; i < n; i++) m_bits.push_back(pl[i]);
        m_prev = x;
    endtask

    task automatic model_edge(input bit rst_v, input bit tx_v, input bit fct_v);
        int k;
        bit b;
        bit load_data;
        bit credit_ok;
        m_ren = 1'b0;
        m_sent = 1'b0;
        load_data = 1'b0;
        if (fct_v) m_fct_seen++;
        if (!rst_v) begin
            m_idle = 1'b1; m_load_at = -1; m_stop_at = -1; m_start = -1;
            m_d = 1'b0; m_s = 1'b0; m_prev = 1'b0; m_credit = 0;
            m_bits.delete();
            return;
        end
`ifdef DS_TX_CREDIT_EN
        credit_ok = (m_credit > 0);
`else
        credit_ok = 1'b1;
`endif
        if (m_idle) begin
            if (tx_v) begin
                m_idle = 1'b0;
                m_load_at = cyc + 1;
                m_start = -1;
            end
        end else if (cyc == m_load_at) begin
            m_bits.delete();
            if (fifo_q.size() != 0 && credit_ok) begin
                put_char(1'b0, fifo_q[0], 8);
                m_is_data = 1'b1;
                m_ren = 1'b1;
                load_data = 1'b1;
                ren_expected++;
            end else begin
                put_char(1'b1, 8'h03, 2);   // ESC
                put_char(1'b1, 8'h00, 2);   // FCT
                m_is_data = 1'b0;
            end
            m_start = cyc + 1;
            m_end = m_start + m_bits.size() * DIV;
            m_load_at = -1;
            m_stop_at = -1;
        end else if (m_start >= 0 && cyc >= m_start) begin
            k = cyc - m_start;
            if ((k % DIV) == 0 && (k / DIV) < m_bits.size()) begin
                b = m_bits[k / DIV];
                if (b == m_d) m_s = ~m_s;
                m_d = b;
                if (m_is_data && (k / DIV) == 9) m_sent = 1'b1;
            end
            if (cyc == m_end - 2) begin
                if (tx_v) m_load_at = m_end - 1;
                else      m_stop_at = m_end;
            end
            if (cyc == m_stop_at) begin
                m_idle = 1'b1; m_d = 1'b0; m_s = 1'b0; m_prev = 1'b0; m_start = -1;
            end
        end
`ifdef DS_TX_CREDIT_EN
        m_credit = m_credit + (fct_v ? 8 : 0) - (load_data ? 1 : 0);
        if (m_credit > 56) m_credit = 56;
`endif
    endtask

    // One clock: inputs already set at the falling edge
    task automatic step();
        bit rst_v, tx_v, fct_v, ren_v;
        rst_v = rst_n;
        tx_v  = tx_en;
        fct_v = credit_fct;
        ren_v = bus.fifo_r_en;
        @(posedge clk);
        model_edge(rst_v, tx_v, fct_v);
        #1;
        if (ren_v) begin
            ren_seen++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            fifo_drive();
        end
        check("d_out", bus.d_out, m_d);
        check("s_out", bus.s_out, m_s);
        check("fifo_r_en", bus.fifo_r_en, m_ren);
        check("char_sent", bus.char_sent, m_sent);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [7:0] null_d_pat = 8'b0010_1110;
    logic [7:0] null_s_pat = 8'b0111_1011;
    int ren_mark;
    int sz;

    initial begin
        rst_n = 1'b0;
        tx_en = 1'b0;
        credit_fct = 1'b0;
        fifo_drive();

        // Reset state
        run(4);

        // Idle NULLs: exact bit pattern of the first NULL
        rst_n = 1'b1;
        tx_en = 1'b1;
        run(2);
        for (int i = 0; i < 8; i++) begin
            step();
            check("null_d", bus.d_out, null_d_pat[i]);
            check("null_s", bus.s_out, null_s_pat[i]);
            run(DIV - 1);
        end
        run(40);
        check("idle_no_ren", ren_seen, 0);

        // Single byte arriving mid-NULL
        run(5);
        ren_mark = ren_seen;
        push(8'hA5);
        run(100);
        check("single_ren", ren_seen - ren_mark, 1);
        check("single_fill", bus.fifo_fill_level, 0);

        // Back-to-back preloaded bytes
        tx_en = 1'b0;
        run(60);
        push(8'h01); push(8'h02); push(8'h03);
        ren_mark = ren_seen;
        tx_en = 1'b1;
        run(140);
        check("b2b_ren", ren_seen - ren_mark, 3);
        check("b2b_fill", bus.fifo_fill_level, 0);

        // Randomised traffic, enable toggles, credits and resets
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) push(8'($urandom));
            if ($urandom_range(0, 99) == 0) tx_en = ~tx_en;
            credit_fct = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n = 1'b1;
        credit_fct = 1'b0;

        // tx_en dropped at bit 3 of a data character
        tx_en = 1'b0;
        run(60);
        fifo_q.delete();
        fifo_drive();
        push(8'h5A); push(8'h11); push(8'h22);
        ren_mark = ren_seen;
        tx_en = 1'b1;
        run(2 + 3 * DIV + 1);
        tx_en = 1'b0;
        run(60);
        check("drop_fill", bus.fifo_fill_level, 2);
        check("drop_ren", ren_seen - ren_mark, 1);
        check("drop_d", bus.d_out, 0);
        check("drop_s", bus.s_out, 0);

        // Reset at bit 5 of a data character, then restart
        run(10);
        fifo_q.delete();
        fifo_drive();
        push(8'h3C);
        tx_en = 1'b1;
        run(2 + 5 * DIV + 1);
        sz = fifo_q.size();
        rst_n = 1'b0;
        step();
        check("rst_d", bus.d_out, 0);
        check("rst_s", bus.s_out, 0);
        check("rst_fill", bus.fifo_fill_level, sz);
        step();
        rst_n = 1'b1;
        run(3);
        check("restart_p", bus.d_out, 0);
        check("restart_s", bus.s_out, 1);
        run(40);

`ifdef DS_TX_CREDIT_EN
        // Credit limit: no data without credit, one FCT buys eight chars
        rst_n = 1'b0;
        tx_en = 1'b0;
        run(2);
        fifo_q.delete();
        fifo_drive();
        for (int i = 0; i < 10; i++) push(8'(i + 8'h40));
        rst_n = 1'b1;
        tx_en = 1'b1;
        ren_mark = ren_seen;
        run(100);
        check("credit0_ren", ren_seen - ren_mark, 0);
        credit_fct = 1'b1;
        step();
        credit_fct = 1'b0;
        run(450);
        check("credit_ren", ren_seen - ren_mark, 8);
        check("credit_fill", bus.fifo_fill_level, 2);
`endif

        check("ren_total", ren_seen, ren_expected);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
